// File: rtl/mem_write_master_if.sv
// -----------------------------------------------------------------------------
// mem_write_master_if
//
// Bundles the store-queue push side, the bus write side and the status flags of
// mem_write_master. Parameters must match the ones given to mem_write_master.
//
//   push/push_addr/push_data : enqueue one store
//   stall                    : responder not ready, current write held
//   addr/data/wen            : registered bus write
//   full/busy/overflow/count : queue status
//
// Modports:
//   master : the write master (drives the bus and status)
//   slave  : the producer/responder side (drives push and stall)
// -----------------------------------------------------------------------------
interface mem_write_master_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 30,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;
    logic          stall;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wen;
    logic          full;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] count;

    modport master (
        input  push, push_addr, push_data, stall,
        output addr, data, wen, full, busy, overflow, count
    );

    modport slave (
        output push, push_addr, push_data, stall,
        input  addr, data, wen, full, busy, overflow, count
    );
endinterface

// File: rtl/mem_write_master.sv
// -----------------------------------------------------------------------------
// mem_write_master
//
// Queues stores in a DEPTH-entry FIFO and issues them one at a time as
// registered bus writes (addr/data/wen). A write is held while stall is high
// and completes on the first rising edge with stall low.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : mem_write_master_if.master
//          push/push_addr/push_data in, stall in,
//          addr/data/wen out (registered), full/busy/overflow/count out
//
// count is the number of queued entries and excludes the store currently on
// the bus. A push while full is dropped and sets the sticky overflow flag.
//
// Build option:
//   WR_GAP_EN : when defined, every completed write is followed by one GAP
//               cycle with wen=0 so each store is a distinct wen pulse. When
//               undefined, back-to-back stores keep wen=1 continuously and the
//               GAP state is never entered.
// -----------------------------------------------------------------------------
module mem_write_master #(
    parameter int DEPTH = 4,
    parameter int AW    = 30,
    parameter int DW    = 32
) (
    input logic               clk,
    input logic               rst,
    mem_write_master_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state, state_d;

    // Store queue
    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    // Bus registers
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          wen_q;

    logic          full;
    logic          accept;
    logic          pop;
    logic          wen_d;

    assign full   = (count_q == CW'(DEPTH));
    assign accept = bus.push && !full;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking for every sequential register so all state
            // updates see pre-edge values, independent of block ordering.
            state <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d = state;
        pop     = 1'b0;
        wen_d   = wen_q;

        unique case (state)
            IDLE: begin
                wen_d = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    wen_d   = 1'b1;
                    state_d = WRITE;
                end
            end

            WRITE: begin
                if (!bus.stall) begin
`ifdef WR_GAP_EN
                    wen_d   = 1'b0;
                    state_d = GAP;
`else
                    // Chain straight into the next store without dropping wen.
                    if (count_q != '0) begin
                        pop   = 1'b1;
                        wen_d = 1'b1;
                    end else begin
                        wen_d   = 1'b0;
                        state_d = IDLE;
                    end
`endif
                end
            end

            GAP: begin
                // The gap cycle itself always shows wen=0. If more work is
                // queued, the pop that IDLE would perform is taken on this
                // edge so queued stores appear as 1,0,1,0 on wen.
                wen_d = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    wen_d   = 1'b1;
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                wen_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Queue storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; entries are only ever read after
    // being written, and count/pointers (which are reset) define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_addr[wr_ptr] <= bus.push_addr;
            mem_data[wr_ptr] <= bus.push_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, count, overflow and bus registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wen_q      <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                addr_q <= mem_addr[rd_ptr];
                data_q <= mem_data[rd_ptr];
            end
            count_q <= count_q + CW'(accept) - CW'(pop);
            if (bus.push && full) begin
                overflow_q <= 1'b1;
            end
            wen_q <= wen_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.addr     = addr_q;
    assign bus.data     = data_q;
    assign bus.wen      = wen_q;
    assign bus.full     = full;
    assign bus.busy     = (state != IDLE) || (count_q != '0);
    assign bus.overflow = overflow_q;
    assign bus.count    = count_q;

endmodule

// File: tb/tb_mem_write_master.sv
// -----------------------------------------------------------------------------
// tb_mem_write_master
//
// Directed bench for mem_write_master (DEPTH=4, AW=30, DW=32). Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// Expected wen patterns depend on whether WR_GAP_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_write_master;
    localparam int DEPTH = 4;
    localparam int AW    = 30;
    localparam int DW    = 32;

    logic clk;
    logic rst;

    int tests;
    int fails;

    // Stores observed completing on the bus (wen=1 sampled with stall=0)
    logic [AW-1:0] seen_addr [16];
    logic [DW-1:0] seen_data [16];
    int            seen_n;

    mem_write_master_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    mem_write_master #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.push      = 1'b0;
        bus.push_addr = '0;
        bus.push_data = '0;
        bus.stall     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.push      = 1'b1;
        bus.push_addr = a;
        bus.push_data = d;
    endtask

    // Gathers completed stores over a fixed number of cycles, starting with
    // the current sample.
    task automatic collect(input int cycles);
        seen_n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.wen === 1'b1 && bus.stall === 1'b0 && seen_n < 16) begin
                seen_addr[seen_n] = bus.addr;
                seen_data[seen_n] = bus.data;
                seen_n++;
            end
            tick();
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst           = 1'b1;
        bus.push      = 1'b0;
        bus.push_addr = '0;
        bus.push_data = '0;
        bus.stall     = 1'b0;
        #1;
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b want 0", bus.wen); end
        tests++; if (bus.addr !== '0) begin fails++; $display("FAIL reset_addr: got %0h want 0", bus.addr); end
        tests++; if (bus.data !== '0) begin fails++; $display("FAIL reset_data: got %0h want 0", bus.data); end
        tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", bus.full); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        tick();
        rst = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single();
        do_reset();
        set_push(30'd0, 32'd65);
        tick();
        bus.push = 1'b0;
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL single_wen_e0: got %b want 0", bus.wen); end
        tests++; if (bus.count !== 3'd1) begin fails++; $display("FAIL single_count_e0: got %0d want 1", bus.count); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL single_busy_e0: got %b want 1", bus.busy); end
        tick();
        tests++; if (bus.wen !== 1'b1) begin fails++; $display("FAIL single_wen_e1: got %b want 1", bus.wen); end
        tests++; if (bus.addr !== 30'd0) begin fails++; $display("FAIL single_addr: got %0d want 0", bus.addr); end
        tests++; if (bus.data !== 32'd65) begin fails++; $display("FAIL single_data: got %0d want 65", bus.data); end
        tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL single_count_e1: got %0d want 0", bus.count); end
        tick();
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL single_wen_e2: got %b want 0", bus.wen); end
        tick();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_stall();
        int high_cnt;
        do_reset();
        set_push(30'd0, 32'd65);
        tick();
        bus.push = 1'b0;
        tick();
        high_cnt = (bus.wen === 1'b1) ? 1 : 0;
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.wen === 1'b1) high_cnt++;
            tests++; if (bus.addr !== 30'd0 || bus.data !== 32'd65) begin
                fails++; $display("FAIL stall_hold_%0d: got addr=%0d data=%0d want addr=0 data=65", i, bus.addr, bus.data);
            end
        end
        bus.stall = 1'b0;
        tick();
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL stall_release_wen: got %b want 0", bus.wen); end
        tests++; if (high_cnt !== 6) begin fails++; $display("FAIL stall_wen_cycles: got %0d want 6", high_cnt); end
        high_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.wen === 1'b1) high_cnt++;
        end
        tests++; if (high_cnt !== 0) begin fails++; $display("FAIL stall_single_completion: got %0d extra wen cycles want 0", high_cnt); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL stall_busy_end: got %b want 0", bus.busy); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_overflow();
        logic [AW-1:0] exp_a [5];
        logic [DW-1:0] exp_d [5];
        exp_a[0] = 30'd100; exp_d[0] = 32'd99;
        for (int i = 1; i < 5; i++) begin
            exp_a[i] = AW'(i);
            exp_d[i] = DW'(9 + i);
        end
        do_reset();
        // Occupy the bus with a stalled store so the queue itself can fill.
        bus.stall = 1'b1;
        set_push(30'd100, 32'd99);
        tick();
        bus.push = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            set_push(AW'(i), DW'(9 + i));
            tick();
            if (i == 3) begin
                tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL ovf_full_at3: got %b want 0", bus.full); end
            end
        end
        tests++; if (bus.full !== 1'b1) begin fails++; $display("FAIL ovf_full_at4: got %b want 1", bus.full); end
        tests++; if (bus.count !== 3'd4) begin fails++; $display("FAIL ovf_count_at4: got %0d want 4", bus.count); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_flag_early: got %b want 0", bus.overflow); end
        set_push(30'd5, 32'd14);
        tick();
        bus.push = 1'b0;
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag_set: got %b want 1", bus.overflow); end
        tests++; if (bus.count !== 3'd4) begin fails++; $display("FAIL ovf_count_after_drop: got %0d want 4", bus.count); end
        bus.stall = 1'b0;
        collect(14);
        tests++; if (seen_n !== 5) begin fails++; $display("FAIL ovf_store_count: got %0d want 5", seen_n); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (seen_addr[i] !== exp_a[i] || seen_data[i] !== exp_d[i]) begin
                fails++; $display("FAIL ovf_order_%0d: got addr=%0d data=%0d want addr=%0d data=%0d", i, seen_addr[i], seen_data[i], exp_a[i], exp_d[i]);
            end
        end
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ovf_busy_end: got %b want 0", bus.busy); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [3:0] exp_wen;
        logic [3:0] got_wen;
        logic [AW-1:0] got_a [4];
`ifdef WR_GAP_EN
        exp_wen = 4'b0101;   // bit i = sample i: 1,0,1,0
`else
        exp_wen = 4'b0011;   // 1,1,0,0
`endif
        do_reset();
        set_push(30'd30, 32'd300);
        tick();
        set_push(30'd31, 32'd310);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.push   = 1'b0;
            got_wen[i] = bus.wen;
            got_a[i]   = bus.addr;
        end
        tests++; if (got_wen !== exp_wen) begin fails++; $display("FAIL b2b_wen_pattern: got %b want %b (bit0 first)", got_wen, exp_wen); end
        tests++; if (got_a[0] !== 30'd30) begin fails++; $display("FAIL b2b_addr_a: got %0d want 30", got_a[0]); end
`ifdef WR_GAP_EN
        tests++; if (got_a[2] !== 30'd31) begin fails++; $display("FAIL b2b_addr_b: got %0d want 31", got_a[2]); end
`else
        tests++; if (got_a[1] !== 30'd31) begin fails++; $display("FAIL b2b_addr_b: got %0d want 31", got_a[1]); end
`endif
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_write();
        int high_cnt;
        do_reset();
        bus.stall = 1'b1;
        set_push(30'd7, 32'd70);
        tick();
        bus.push = 1'b0;
        tick();
        set_push(30'd8, 32'd80);
        tick();
        set_push(30'd9, 32'd90);
        tick();
        bus.push = 1'b0;
        tests++; if (bus.wen !== 1'b1 || bus.count !== 3'd2) begin
            fails++; $display("FAIL rstmid_setup: got wen=%b count=%0d want wen=1 count=2", bus.wen, bus.count);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL rstmid_wen: got %b want 0", bus.wen); end
        tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL rstmid_count: got %0d want 0", bus.count); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        tests++; if (bus.addr !== '0 || bus.data !== '0) begin fails++; $display("FAIL rstmid_bus: got addr=%0d data=%0d want 0/0", bus.addr, bus.data); end
        tick();
        rst       = 1'b0;
        bus.stall = 1'b0;
        high_cnt  = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.wen === 1'b1) high_cnt++;
        end
        tests++; if (high_cnt !== 0) begin fails++; $display("FAIL rstmid_no_writes: got %0d wen cycles want 0", high_cnt); end
        set_push(30'd11, 32'd110);
        tick();
        bus.push = 1'b0;
        tests++; if (bus.wen !== 1'b0) begin fails++; $display("FAIL rstmid_push_e0: got %b want 0", bus.wen); end
        tick();
        tests++; if (bus.wen !== 1'b1 || bus.addr !== 30'd11 || bus.data !== 32'd110) begin
            fails++; $display("FAIL rstmid_push_e1: got wen=%b addr=%0d data=%0d want 1/11/110", bus.wen, bus.addr, bus.data);
        end
        tick();
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_push_pop();
        do_reset();
        bus.stall = 1'b1;
        set_push(30'd20, 32'd200);
        tick();
        bus.push = 1'b0;
        tick();
        set_push(30'd21, 32'd210);
        tick();
        set_push(30'd22, 32'd220);
        tick();
        bus.push = 1'b0;
        tests++; if (bus.count !== 3'd2) begin fails++; $display("FAIL pp_count_before: got %0d want 2", bus.count); end
        bus.stall = 1'b0;
`ifdef WR_GAP_EN
        // Completion edge enters GAP; the pop happens on the following edge.
        tick();
`endif
        set_push(30'd23, 32'd230);
        tick();
        bus.push = 1'b0;
        tests++; if (bus.count !== 3'd2) begin fails++; $display("FAIL pp_count_after: got %0d want 2", bus.count); end
        tests++; if (bus.wen !== 1'b1 || bus.addr !== 30'd21) begin
            fails++; $display("FAIL pp_head: got wen=%b addr=%0d want 1/21", bus.wen, bus.addr);
        end
        collect(10);
        tests++; if (seen_n !== 3) begin fails++; $display("FAIL pp_store_count: got %0d want 3", seen_n); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (seen_addr[i] !== AW'(21 + i) || seen_data[i] !== DW'(210 + 10 * i)) begin
                fails++; $display("FAIL pp_order_%0d: got addr=%0d data=%0d want addr=%0d data=%0d", i, seen_addr[i], seen_data[i], 21 + i, 210 + 10 * i);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_mid_write();
        test_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got time %0t want < 100000", $time);
        $fatal(1);
    end
endmodule
